nios_cpu_debug_slave_sysclk_mc: RTL and testbench

Parametrised system-clock half of the Nios II JTAG debug slave. It receives toggle-encoded update-IR and update-DR events from the TCK-domain shift logic and synchronises them into `clk`. Each update-DR capture, tagged with its instruction code, is queued in a small FIFO so back-to-back JTAG scans survive a stalled CPU. Entries are drained as per-channel one-cycle `take_action` / `take_no_action` pulses with the captured data on `jdo`. It sits between the virtual-JTAG TCK-domain block and the OCI break, ocimem and trace-control consumers.

---
 rtl/nios_cpu_debug_slave_sysclk_mc.sv | 143 ++++++++++++++
 tb/tb_nios_cpu_debug_slave_sysclk_mc.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/nios_cpu_debug_slave_sysclk_mc.sv
// System-clock half of the Nios II JTAG debug slave: synchronises TCK-domain
// update-IR/update-DR toggles and drains queued DR captures as per-channel pulses.
module nios_cpu_debug_slave_sysclk_mc #(
    parameter int SR_W        = 38,
    parameter int IR_W        = 2,
    parameter int ACT_BIT     = 35,
    parameter int SYNC_STAGES = 2,
    parameter int DEPTH       = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      uir_tog,
    input  logic                      udr_tog,
    input  logic [IR_W-1:0]           ir_in,
    input  logic [SR_W-1:0]           sr,
    input  logic                      stall,
    input  logic                      overrun_clr,
    output logic [SR_W-1:0]           jdo,
    output logic [IR_W-1:0]           ir_cur,
    output logic                      uir_pulse,
    output logic [2**IR_W-1:0]        take_action,
    output logic [2**IR_W-1:0]        take_no_action,
    output logic [$clog2(DEPTH):0]    fifo_count,
    output logic                      overrun
);

    localparam int N_CH = 2**IR_W;
    localparam int AW   = $clog2(DEPTH);
    localparam int CW   = AW + 1;
    localparam int EW   = IR_W + SR_W;

    logic [SYNC_STAGES-1:0] uir_sync_q, udr_sync_q;
    logic                   uir_prev_q, udr_prev_q;
    logic                   uir_evt, udr_evt;

    logic [IR_W-1:0]        ir_cur_q;
    logic                   uir_pulse_q;

    logic [EW-1:0]          mem_q [DEPTH];
    logic [AW-1:0]          wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]          count_q, count_d;
    logic                   full, pop, push_ok, overflow;
    logic [IR_W-1:0]        push_tag;
    logic [EW-1:0]          rd_entry;
    logic [IR_W-1:0]        entry_tag;
    logic [SR_W-1:0]        entry_sr;

    logic [SR_W-1:0]        jdo_q, jdo_d;
    logic [N_CH-1:0]        act_q, act_d, nact_q, nact_d;
    logic                   overrun_q, overrun_d;

    assign uir_evt = uir_sync_q[SYNC_STAGES-1] ^ uir_prev_q;
    assign udr_evt = udr_sync_q[SYNC_STAGES-1] ^ udr_prev_q;

    // A DR capture that coincides with an IR update belongs to the new instruction.
    assign push_tag = uir_evt ? ir_in : ir_cur_q;

    assign full     = (count_q == CW'(DEPTH));
    assign pop      = (count_q != '0) && !stall;
    assign push_ok  = udr_evt && (!full || pop);
    assign overflow = udr_evt && full && !pop;

    assign rd_entry  = mem_q[rd_ptr_q];
    assign entry_tag = rd_entry[EW-1:SR_W];
    assign entry_sr  = rd_entry[SR_W-1:0];

    always_comb begin
        count_d = count_q;
        if (push_ok && !pop)
            count_d = count_q + CW'(1);
        else if (!push_ok && pop)
            count_d = count_q - CW'(1);
    end

    always_comb begin
        act_d  = '0;
        nact_d = '0;
        jdo_d  = jdo_q;
        if (pop) begin
            jdo_d             = entry_sr;
            act_d[entry_tag]  = entry_sr[ACT_BIT];
            nact_d[entry_tag] = ~entry_sr[ACT_BIT];
        end
    end

    always_comb begin
        overrun_d = overrun_q;
        if (overflow)
            overrun_d = 1'b1;
        else if (overrun_clr)
            overrun_d = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            uir_sync_q  <= '0;
            udr_sync_q  <= '0;
            uir_prev_q  <= 1'b0;
            udr_prev_q  <= 1'b0;
            ir_cur_q    <= '0;
            uir_pulse_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            jdo_q       <= '0;
            act_q       <= '0;
            nact_q      <= '0;
            overrun_q   <= 1'b0;
        end else begin
            uir_sync_q  <= {uir_sync_q[SYNC_STAGES-2:0], uir_tog};
            udr_sync_q  <= {udr_sync_q[SYNC_STAGES-2:0], udr_tog};
            uir_prev_q  <= uir_sync_q[SYNC_STAGES-1];
            udr_prev_q  <= udr_sync_q[SYNC_STAGES-1];
            uir_pulse_q <= uir_evt;
            if (uir_evt)
                ir_cur_q <= ir_in;
            if (push_ok)
                wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)
                rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q     <= count_d;
            jdo_q       <= jdo_d;
            act_q       <= act_d;
            nact_q      <= nact_d;
            overrun_q   <= overrun_d;
        end
    end

    // Storage needs no reset: pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok)
            mem_q[wr_ptr_q] <= {push_tag, sr};
    end

    assign jdo            = jdo_q;
    assign ir_cur         = ir_cur_q;
    assign uir_pulse      = uir_pulse_q;
    assign take_action    = act_q;
    assign take_no_action = nact_q;
    assign fifo_count     = count_q;
    assign overrun        = overrun_q;

endmodule

// File: tb/tb_nios_cpu_debug_slave_sysclk_mc.sv
// Directed bench for the debug-slave sysclk block; popped pulses are checked
// against a queue of expected {tag, sr} entries filled as update-DRs are driven.
module tb_nios_cpu_debug_slave_sysclk_mc;
    localparam int SR_W = 38;
    localparam int IR_W = 2;
    localparam int N_CH = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              uir_tog, udr_tog;
    logic [IR_W-1:0]   ir_in;
    logic [SR_W-1:0]   sr;
    logic              stall, overrun_clr;
    logic [SR_W-1:0]   jdo;
    logic [IR_W-1:0]   ir_cur;
    logic              uir_pulse;
    logic [N_CH-1:0]   take_action, take_no_action;
    logic [2:0]        fifo_count;
    logic              overrun;

    logic [IR_W+SR_W-1:0] exp_q[$];
    logic [IR_W-1:0]      model_ir;
    int                   checks = 0;
    int                   errors = 0;

    always #5 clk = ~clk;

    nios_cpu_debug_slave_sysclk_mc #(
        .SR_W(SR_W), .IR_W(IR_W), .ACT_BIT(35), .SYNC_STAGES(2), .DEPTH(4)
    ) dut (
        .clk(clk), .reset(reset), .uir_tog(uir_tog), .udr_tog(udr_tog),
        .ir_in(ir_in), .sr(sr), .stall(stall), .overrun_clr(overrun_clr),
        .jdo(jdo), .ir_cur(ir_cur), .uir_pulse(uir_pulse),
        .take_action(take_action), .take_no_action(take_no_action),
        .fifo_count(fifo_count), .overrun(overrun)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic udr(input logic [SR_W-1:0] d, input bit accept);
        sr = d;
        udr_tog = ~udr_tog;
        if (accept) exp_q.push_back({model_ir, d});
    endtask

    // Scoreboard: every pulse must match the oldest accepted capture.
    always @(negedge clk) begin : mon
        logic [IR_W+SR_W-1:0] e;
        logic [N_CH-1:0]      ea, en;
        if (!reset && (take_action != '0 || take_no_action != '0)) begin
            check("sb_entry_pending", 64'(exp_q.size() != 0), 64'(1));
            if (exp_q.size() != 0) begin
                e  = exp_q.pop_front();
                ea = e[35] ? (4'b0001 << e[SR_W +: IR_W]) : 4'b0000;
                en = e[35] ? 4'b0000 : (4'b0001 << e[SR_W +: IR_W]);
                check("sb_take_action", 64'(take_action), 64'(ea));
                check("sb_take_no_action", 64'(take_no_action), 64'(en));
                check("sb_jdo", 64'(jdo), 64'(e[SR_W-1:0]));
            end
        end
    end

    logic [SR_W-1:0] data_tbl [8];

    initial begin
        data_tbl = '{38'h8_0000_0001, 38'h0_1234_5678, 38'h8_ABCD_0000, 38'h3_0F0F_0F0F,
                     38'h9_5555_AAAA, 38'h1_DEAD_BEEF, 38'hC_0000_00C3, 38'h2_7777_0001};
        reset = 1'b1; uir_tog = 1'b0; udr_tog = 1'b0; ir_in = '0; sr = '0;
        stall = 1'b0; overrun_clr = 1'b0; model_ir = '0;
        step(2);
        check("rst_jdo", 64'(jdo), 64'(0));
        check("rst_act", 64'(take_action), 64'(0));
        check("rst_nact", 64'(take_no_action), 64'(0));
        check("rst_uir_pulse", 64'(uir_pulse), 64'(0));
        check("rst_count", 64'(fifo_count), 64'(0));
        check("rst_overrun", 64'(overrun), 64'(0));
        check("rst_ir_cur", 64'(ir_cur), 64'(0));
        reset = 1'b0;
        step(3);

        // IR update, then action and no-action DR captures on channel 2
        ir_in = 2'd2; uir_tog = ~uir_tog; model_ir = 2'd2;
        step(3);
        check("uir_pulse_hi", 64'(uir_pulse), 64'(1));
        check("ir_cur_2", 64'(ir_cur), 64'(2));
        step(1);
        check("uir_pulse_lo", 64'(uir_pulse), 64'(0));
        step(1);
        udr(38'h8_0000_00AB, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            step(1);
            if (k < 4) check("lat_early", 64'(take_action), 64'(0));
        end
        check("lat_act", 64'(take_action), 64'(4'b0100));
        check("lat_jdo", 64'(jdo), 64'(38'h8_0000_00AB));
        step(1);
        check("act_single_cycle", 64'(take_action), 64'(0));
        check("jdo_hold", 64'(jdo), 64'(38'h8_0000_00AB));
        udr(38'h2_0000_00AB, 1'b1);
        step(4);
        check("noact_bit2", 64'(take_no_action), 64'(4'b0100));
        check("noact_no_act", 64'(take_action), 64'(0));
        step(2);

        // Backpressure: fill to 4, then drain on consecutive cycles
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            udr(data_tbl[i], 1'b1);
            step(4);
        end
        check("bp_count_full", 64'(fifo_count), 64'(4));
        check("bp_no_overrun", 64'(overrun), 64'(0));
        stall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(1);
            check("bp_pulse", 64'(|(take_action | take_no_action)), 64'(1));
        end
        step(1);
        check("bp_count_empty", 64'(fifo_count), 64'(0));
        check("bp_pulses_done", 64'(take_action | take_no_action), 64'(0));

        // Overrun: fifth capture dropped, sticky flag, clear and clear-vs-set
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            udr(data_tbl[i+2], i < 4);
            step(4);
        end
        check("ov_count", 64'(fifo_count), 64'(4));
        check("ov_set", 64'(overrun), 64'(1));
        overrun_clr = 1'b1; step(1); overrun_clr = 1'b0;
        check("ov_cleared", 64'(overrun), 64'(0));
        udr(data_tbl[7], 1'b0);
        step(2);
        overrun_clr = 1'b1; step(1); overrun_clr = 1'b0;
        check("ov_set_wins", 64'(overrun), 64'(1));
        check("ov_count_kept", 64'(fifo_count), 64'(4));
        step(2);
        overrun_clr = 1'b1; step(1); overrun_clr = 1'b0;
        check("ov_cleared2", 64'(overrun), 64'(0));

        // Full FIFO with a pop on the push edge: push accepted
        udr(data_tbl[1], 1'b1);
        step(2);
        stall = 1'b0;
        step(1);
        check("fullpop_count", 64'(fifo_count), 64'(4));
        check("fullpop_no_overrun", 64'(overrun), 64'(0));
        step(6);
        check("fullpop_drained", 64'(fifo_count), 64'(0));

        // Coincident IR and DR updates: capture tagged with the new IR
        ir_in = 2'd3; uir_tog = ~uir_tog; model_ir = 2'd3;
        udr(38'h0_0000_0033, 1'b1);
        step(6);
        check("coinc_ir_cur", 64'(ir_cur), 64'(3));
        check("sb_drained", 64'(exp_q.size()), 64'(0));

        // Reset with three entries queued
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            udr(data_tbl[i+4], 1'b1);
            step(4);
        end
        check("pre_rst_count", 64'(fifo_count), 64'(3));
        reset = 1'b1; uir_tog = 1'b0; udr_tog = 1'b0;
        exp_q.delete(); model_ir = '0;
        #1;
        check("async_rst_count", 64'(fifo_count), 64'(0));
        check("async_rst_jdo", 64'(jdo), 64'(0));
        check("async_rst_ir_cur", 64'(ir_cur), 64'(0));
        check("async_rst_pulses", 64'(take_action | take_no_action), 64'(0));
        check("async_rst_overrun", 64'(overrun), 64'(0));
        step(2);
        reset = 1'b0; stall = 1'b0;
        step(8);
        check("post_rst_count", 64'(fifo_count), 64'(0));
        check("post_rst_pulses", 64'(take_action | take_no_action), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
